// File: rtl/udiv_pkg.sv
// -----------------------------------------------------------------------------
// udiv_pkg
// Shared types and constants for the sequential 16-by-8 unsigned divider.
//   udiv_state_t   : controller state (IDLE, CALC, DONE)
//   UDIV_ZW/YW/QW  : dividend, divisor and quotient widths
//   UDIV_Q_ERR     : quotient value reported on divide-by-zero / overflow
//   UDIV_REM_ERR   : remainder value reported on divide-by-zero / overflow
//   udiv_overflow(): true when the quotient cannot be represented in 8 bits
// -----------------------------------------------------------------------------
package udiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } udiv_state_t;

    localparam int UDIV_ZW = 16;
    localparam int UDIV_YW = 8;
    localparam int UDIV_QW = 8;

    localparam logic [UDIV_QW-1:0] UDIV_Q_ERR   = 8'hFF;
    localparam logic [UDIV_YW-1:0] UDIV_REM_ERR = 8'hFF;

    // A zero divisor, or a high dividend byte that is already >= y, means the
    // quotient needs more than 8 bits.
    function automatic logic udiv_overflow(
        input logic [UDIV_YW-1:0] z_hi,
        input logic [UDIV_YW-1:0] y
    );
        return (y == 8'd0) || (z_hi >= y);
    endfunction

endpackage

// File: rtl/udiv_step.sv
// -----------------------------------------------------------------------------
// udiv_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
//   pr      [8:0] in  : current partial remainder (always < y)
//   zbit          in  : next dividend bit, MSB first
//   y       [7:0] in  : divisor
//   pr_next [8:0] out : partial remainder after this step
//   qbit          out : quotient bit produced by this step
// -----------------------------------------------------------------------------
module udiv_step
    import udiv_pkg::*;
(
    input  logic [UDIV_YW:0]   pr,
    input  logic               zbit,
    input  logic [UDIV_YW-1:0] y,
    output logic [UDIV_YW:0]   pr_next,
    output logic               qbit
);

    logic [UDIV_YW:0] t_s;
    logic             ge_s;

    // Trial subtraction; pr[8] is zero whenever pr < y, and if it were ever set
    // the true shifted value would exceed any 8-bit divisor anyway.
    always_comb begin
        t_s  = {pr[UDIV_YW-1:0], zbit};
        ge_s = (t_s >= {1'b0, y}) || pr[UDIV_YW];
        if (ge_s) begin
            pr_next = t_s - {1'b0, y};
            qbit    = 1'b1;
        end else begin
            pr_next = t_s;
            qbit    = 1'b0;
        end
    end

endmodule

// File: rtl/unsigned_16by8_div_seq.sv
// -----------------------------------------------------------------------------
// unsigned_16by8_div_seq
// Sequential unsigned restoring divider: q = z / y, rem = z % y, one quotient
// bit per clock behind a valid/ready handshake. Quotient overflow and divide by
// zero finish immediately with err = 1 and q = rem = 8'hFF.
//
// Build option: define UDIV_TRUNC_EN for approximate mode, which computes only
// the TRUNC_ITERS quotient MSBs (remaining LSBs 0) and forces rem to 0.
//
// Parameters
//   TRUNC_ITERS : quotient MSBs computed when UDIV_TRUNC_EN is defined (1..8)
// Ports
//   clk        in       : clock, rising edge
//   rst        in       : asynchronous active-high reset
//   in_valid   in       : z/y valid
//   in_ready   out      : divider idle, can accept operands
//   z          in  [15] : dividend
//   y          in  [7]  : divisor
//   out_valid  out      : q/rem/err valid
//   out_ready  in       : consumer takes the result
//   q          out [7]  : quotient
//   rem        out [7]  : remainder
//   err        out      : divide-by-zero or quotient overflow
// -----------------------------------------------------------------------------
module unsigned_16by8_div_seq
    import udiv_pkg::*;
#(
    parameter int TRUNC_ITERS = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [UDIV_ZW-1:0] z,
    input  logic [UDIV_YW-1:0] y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [UDIV_QW-1:0] q,
    output logic [UDIV_YW-1:0] rem,
    output logic               err
);

`ifdef UDIV_TRUNC_EN
    localparam bit TRUNC_MODE = 1'b1;
`else
    localparam bit TRUNC_MODE = 1'b0;
`endif

    // Quotient bit index of the final CALC iteration.
    localparam logic [2:0] LAST_BIT = TRUNC_MODE ? 3'(UDIV_QW - TRUNC_ITERS) : 3'd0;

    udiv_state_t        state_q, state_d;
    logic [7:0]         zl_q, zl_d;      // low dividend byte, consumed MSB first
    logic [UDIV_YW-1:0] y_q, y_d;
    logic [UDIV_YW:0]   pr_q, pr_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [UDIV_QW-1:0] q_q, q_d;
    logic [UDIV_YW-1:0] rem_q, rem_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [UDIV_YW:0]   step_pr_s;
    logic               step_qbit_s;

    udiv_step u_step (
        .pr      (pr_q),
        .zbit    (zl_q[cnt_q]),
        .y       (y_q),
        .pr_next (step_pr_s),
        .qbit    (step_qbit_s)
    );

    // Next-state and datapath update for the IDLE/CALC/DONE controller.
    always_comb begin
        state_d = state_q;
        zl_d    = zl_q;
        y_d     = y_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rem_d   = rem_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (udiv_overflow(z[UDIV_ZW-1:8], y)) begin
                        q_d     = UDIV_Q_ERR;
                        rem_d   = UDIV_REM_ERR;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        zl_d    = z[7:0];
                        y_d     = y;
                        pr_d    = {1'b0, z[UDIV_ZW-1:8]};
                        cnt_d   = 3'd7;
                        q_d     = 8'd0;
                        rem_d   = 8'd0;
                        err_d   = 1'b0;
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                pr_d       = step_pr_s;
                q_d[cnt_q] = step_qbit_s;
                if (cnt_q == LAST_BIT) begin
                    rem_d   = TRUNC_MODE ? 8'd0 : step_pr_s[UDIV_YW-1:0];
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state decode.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            zl_q        <= 8'd0;
            y_q         <= 8'd0;
            pr_q        <= 9'd0;
            cnt_q       <= 3'd0;
            q_q         <= 8'd0;
            rem_q       <= 8'd0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zl_q        <= zl_d;
            y_q         <= y_d;
            pr_q        <= pr_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign rem       = rem_q;
    assign err       = err_q;

endmodule

// File: tb/tb_unsigned_16by8_div_seq.sv
// -----------------------------------------------------------------------------
// tb_unsigned_16by8_div_seq
// Directed and random checks of the sequential divider with a result
// scoreboard fed from an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_unsigned_16by8_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] z;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q;
    logic [7:0]  rem;
    logic        err;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] rem;
        logic       err;
    } res_t;

`ifdef UDIV_TRUNC_EN
    localparam int         EXP_ITERS = 6;
    localparam logic [7:0] Q_MASK    = 8'hFC;
`else
    localparam int         EXP_ITERS = 8;
`endif

    res_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    unsigned_16by8_div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .rem       (rem),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] zz, input logic [7:0] yy);
        res_t        r;
        int unsigned qq;
        int unsigned rr;
        if (yy == 8'd0 || zz[15:8] >= yy) begin
            r.q   = 8'hFF;
            r.rem = 8'hFF;
            r.err = 1'b1;
        end else begin
            qq    = int'(zz) / int'(yy);
            rr    = int'(zz) % int'(yy);
            r.q   = qq[7:0];
            r.rem = rr[7:0];
            r.err = 1'b0;
`ifdef UDIV_TRUNC_EN
            r.q   = r.q & Q_MASK;
            r.rem = 8'd0;
`endif
        end
        return r;
    endfunction

    // One full transaction: accept, wait for the result, optional stall, hand-off.
    task automatic do_div(input logic [15:0] zz, input logic [7:0] yy, input int stall);
        res_t e;
        int   lat;
        lat = 0;
        while (!in_ready && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        z        = zz;
        y        = yy;
        in_valid = 1'b1;
        sb.push_back(model(zz, yy));
        @(posedge clk); #1;
        in_valid = 1'b0;
        z        = 16'($urandom);
        y        = 8'($urandom);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 30) begin
            in_valid = 1'($urandom_range(0, 1));
            z        = 16'($urandom);
            y        = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("latency", 32'(lat), e.err ? 32'd0 : 32'(EXP_ITERS));
        chk("q", 32'(q), 32'(e.q));
        chk("rem", 32'(rem), 32'(e.rem));
        chk("err", 32'(err), 32'(e.err));
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                in_valid = 1'b1;
                z        = 16'($urandom);
                y        = 8'($urandom);
                @(posedge clk); #1;
                chk("stall_q", 32'(q), 32'(e.q));
                chk("stall_rem", 32'(rem), 32'(e.rem));
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("handoff_valid", 32'(out_valid), 32'd0);
        chk("handoff_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0]  ry;
        logic [15:0] rz;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        z         = 16'd0;
        y         = 8'd0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_rem", 32'(rem), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        do_div(16'd1000, 8'd7, 0);
        do_div(16'hFE01, 8'd255, 0);
        do_div(16'hFFFF, 8'd255, 0);
        do_div(16'h1234, 8'd0, 0);
        do_div(16'h00FF, 8'd1, 0);
        do_div(16'd500, 8'd9, 5);

        // Abort mid-calculation with an asynchronous reset pulse.
        z        = 16'd1000;
        y        = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_q", 32'(q), 32'd0);
        chk("abort_rem", 32'(rem), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_div(16'd1000, 8'd7, 0);

        // Random in-range divisions.
        for (int k = 0; k < 20; k++) begin
            ry = 8'($urandom_range(1, 255));
            rz = 16'($urandom_range(0, int'(ry) * 256 - 1));
            do_div(rz, ry, 0);
        end
        // Random overflow and divide-by-zero cases.
        for (int k = 0; k < 4; k++) begin
            ry = 8'($urandom_range(0, 200));
            rz = {8'($urandom_range(int'(ry), 255)), 8'($urandom)};
            do_div(rz, ry, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unsigned_16by8_div_seq.md
# unsigned_16by8_div_seq

Sequential unsigned restoring divider that inverts the 8x8 unsigned multipliers: given a 16-bit product `z` and an 8-bit factor `y`, it recovers the 8-bit quotient `q = z / y` and the remainder `r = z % y`. It runs one quotient bit per cycle behind a valid/ready handshake. It is used as the reference inverse operation in accuracy benches. It is also used as a standalone divide unit in the same datapath family as the approximate multipliers.

## Interface
- Parameters:
  - `TRUNC_ITERS`, default 6: number of quotient MSBs computed when `UDIV_TRUNC_EN` is defined, legal range 1..8. It is ignored otherwise.
- Ports:
  - `clk` input 1: the only clock; all state updates on its rising edge.
  - `rst` input 1: asynchronous, active-high reset.
  - `in_valid` input 1: operands `z` and `y` are valid.
  - `in_ready` output 1: divider can accept operands.
  - `z` input 16: dividend.
  - `y` input 8: divisor.
  - `out_valid` output 1: result is valid.
  - `out_ready` input 1: consumer accepts the result.
  - `q` output 8: quotient.
  - `rem` output 8: remainder.
  - `err` output 1: divide-by-zero or quotient overflow.

## Operation
- FSM states:
  - IDLE: `in_ready` = 1.
  - CALC: iterating.
  - DONE: `out_valid` = 1.
- Accept happens when `in_valid && in_ready` at an edge. `z` and `y` are latched at that edge. Later changes to the inputs, or dropping `in_valid`, have no effect.
- Error check at accept: `err` is set when `y == 0` or `z[15:8] >= y`, meaning the quotient does not fit in 8 bits.
  - The FSM goes IDLE→DONE directly.
  - Outputs in DONE: `q` = 8'hFF, `rem` = 8'hFF, `err` = 1.
- Normal path at accept:
  - Initialise the 9-bit partial remainder `pr` to `{1'b0, z[15:8]}`.
  - Initialise the bit counter to 7 and clear `q`.
  - Go to CALC.
- Each CALC edge:
  - Form `t = {pr[7:0], z[cnt]}`, 9 bits. Since `pr < y`, `t < 2y` always fits in 9 bits.
  - If `t >= y`: `pr = t - y` and `q[cnt] = 1`.
  - Otherwise: `pr = t` and `q[cnt] = 0`.
  - Decrement `cnt`.
- After the iteration for bit 0: go to DONE with `rem = pr[7:0]` and `err = 0`.
- DONE holds `q`, `rem` and `err` stable until `out_valid && out_ready` at an edge, then the FSM goes to IDLE.
- `in_ready` is low in CALC and DONE. There is no overlap of accept with result hand-off.
- Reset behaviour: `rst` asserted in any state, including mid-CALC, aborts the operation immediately.
  - State returns to IDLE.
  - `q` = 0, `rem` = 0, `err` = 0, `out_valid` = 0, `in_ready` = 1 while out of reset.

## Timing
- Normal latency: accept at edge k, then `out_valid` = 1 after edge k+8 (8 CALC iterations).
- Error latency: `out_valid` = 1 after edge k+1.
- Minimum initiation interval with `out_ready` tied high:
  - 10 cycles for the normal path (accept, 8 iterations, hand-off).
  - 2 cycles for the error path.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `out_ready` low stalls DONE indefinitely with outputs frozen.

## Configuration
- `UDIV_TRUNC_EN` defined: approximate mode.
  - CALC runs only `TRUNC_ITERS` iterations, producing quotient bits 7 down to 8-`TRUNC_ITERS`.
  - The remaining quotient LSBs are 0.
  - `rem` is forced to 0.
  - Latency is `TRUNC_ITERS` cycles.
  - The error path is unchanged.
- `UDIV_TRUNC_EN` not defined: exact divider as above, fixed 8 iterations, and `TRUNC_ITERS` is unused.

## Structure
- Package `udiv_pkg` contains:
  - the state enum `udiv_state_t` (IDLE, CALC, DONE);
  - constants `UDIV_ZW` = 16, `UDIV_YW` = 8, `UDIV_QW` = 8;
  - the error sentinels for `q` and `rem`.
- Sub-module `udiv_step`, combinational, one restoring step:
  - inputs: `pr[8:0]`, `zbit`, `y[7:0]`;
  - outputs: next `pr[8:0]` and `qbit`.
  - It is instantiated once in the top.

## Test plan
- `z` = 1000, `y` = 7, `out_ready` = 1 → after 8 CALC cycles `q` = 142, `rem` = 6, `err` = 0, `in_ready` high again on the next cycle.
- `z` = 16'hFE01, `y` = 255 → `q` = 255, `rem` = 0, `err` = 0. Also `z` = 16'hFFFF, `y` = 255 → `err` = 1, `q` = 8'hFF, `rem` = 8'hFF, `out_valid` one cycle after accept.
- `y` = 0 with any `z` → `err` = 1 and the sentinels. Then divide `z` = 16'h00FF by `y` = 1 → `q` = 255, `rem` = 0, proving recovery.
- `z` = 500, `y` = 9 with `out_ready` low for 5 cycles after `out_valid` → `q` = 55 and `rem` = 5 held stable, `in_ready` = 0 throughout. The inputs are changed during this time and must have no effect.
- `rst` pulsed asynchronously at CALC iteration 4 → all outputs 0 and `in_ready` = 1 immediately. The next divide, 1000/7, is correct.
- With `UDIV_TRUNC_EN` and `TRUNC_ITERS` = 6: 1000/7 → `q` = 140, `rem` = 0, `out_valid` after 6 CALC cycles. Random sweep: `q` equals the exact quotient with its 2 LSBs cleared.
